// File: rtl/result_collector_pkg.sv
// Shared helpers for the result collector slice.
// Pointer sizing is kept here so arbiter and top agree.
package result_collector_pkg;

  function automatic int ptr_w(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/result_collector_arbiter.sv
// Combinational round-robin grant over a request vector.
// The search starts at the supplied pointer and wraps.
module rr_grant_arbiter
  import result_collector_pkg::*;
#(
  parameter  int NumEus = 2,
  localparam int PtrW   = ptr_w(NumEus)
) (
  input  logic [NumEus-1:0] req,
  input  logic              en,
  input  logic [PtrW-1:0]   pointer,
  output logic [NumEus-1:0] grant,
  output logic [PtrW-1:0]   idx
);

  int   j;
  logic hit;

  always_comb begin
    grant = '0;
    idx   = '0;
    hit   = 1'b0;
    j     = 0;
    for (int k = 0; k < NumEus; k++) begin
      j = int'(pointer) + k;
      if (j >= NumEus) j = j - NumEus;
      if (en && !hit && req[PtrW'(j)]) begin
        grant[PtrW'(j)] = 1'b1;
        idx             = PtrW'(j);
        hit             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects EU results into one output stage feeding the RF write port;
// each drained result retires its tag to the dispatcher.
module result_collector
  import result_collector_pkg::*;
#(
  parameter  int NumEus      = 2,
  parameter  int NumTags     = 8,
  parameter  int WarpWidth   = 32,
  parameter  int RegIdxWidth = 6,
  parameter  int RegWidth    = 32,
  localparam int TagWidth    = $clog2(NumTags),
  localparam int DataW       = WarpWidth * RegWidth
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic [NumEus-1:0]                     eu_valid_i,
  output logic [NumEus-1:0]                     eu_ready_o,
  input  logic [NumEus-1:0][TagWidth-1:0]       eu_tag_i,
  input  logic [NumEus-1:0][WarpWidth-1:0]      eu_act_mask_i,
  input  logic [NumEus-1:0][RegIdxWidth-1:0]    eu_dst_i,
  input  logic [NumEus-1:0][DataW-1:0]          eu_data_i,
  output logic                                  rf_valid_o,
  input  logic                                  rf_ready_i,
  output logic [WarpWidth-1:0]                  rf_act_mask_o,
  output logic [RegIdxWidth-1:0]                rf_dst_o,
  output logic [DataW-1:0]                      rf_data_o,
  output logic                                  disp_done_valid_o,
  output logic [TagWidth-1:0]                   disp_done_tag_o
);

  localparam int PtrW = ptr_w(NumEus);

  typedef logic [TagWidth-1:0]    tag_t;
  typedef logic [RegIdxWidth-1:0] reg_idx_t;
  typedef logic [WarpWidth-1:0]   act_mask_t;
  typedef logic [DataW-1:0]       data_t;

  logic      stage_valid;
  tag_t      stage_tag;
  reg_idx_t  stage_dst;
  act_mask_t stage_mask;
  data_t     stage_data;

  logic [PtrW-1:0]   ptr;
  logic [PtrW-1:0]   gidx;
  logic [NumEus-1:0] grant;
  logic              free;
  logic              take;

  assign free = !stage_valid || rf_ready_i;
  assign take = |grant;

  rr_grant_arbiter #(
    .NumEus (NumEus)
  ) u_arb (
    .req     (eu_valid_i),
    .en      (free),
    .pointer (ptr),
    .grant   (grant),
    .idx     (gidx)
  );

  assign eu_ready_o = grant;

  // Draining and refilling in one cycle simply overwrites the stage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_valid <= 1'b0;
      stage_tag   <= '0;
      stage_dst   <= '0;
      stage_mask  <= '0;
      stage_data  <= '0;
      ptr         <= '0;
    end else if (free) begin
      stage_valid <= take;
      if (take) begin
        stage_tag  <= eu_tag_i[gidx];
        stage_dst  <= eu_dst_i[gidx];
        stage_mask <= eu_act_mask_i[gidx];
        stage_data <= eu_data_i[gidx];
        ptr <= (gidx == PtrW'(NumEus - 1)) ? '0 : gidx + 1'b1;
      end
    end
  end

  assign rf_valid_o        = stage_valid;
  assign rf_act_mask_o     = stage_mask;
  assign rf_dst_o          = stage_dst;
  assign rf_data_o         = stage_data;
  assign disp_done_valid_o = stage_valid && rf_ready_i;
  assign disp_done_tag_o   = stage_tag;

`ifndef SYNTHESIS
  logic [NumTags-1:0] inflight;
  logic [NumTags-1:0] tag_set;
  logic [NumTags-1:0] tag_clr;

  always_comb begin
    tag_set = '0;
    tag_clr = '0;
    if (take) tag_set[eu_tag_i[gidx]] = 1'b1;
    if (disp_done_valid_o) tag_clr[stage_tag] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight <= '0;
    else inflight <= (inflight & ~tag_clr) | tag_set;
  end

  a_ready_onehot0: assert property (
    @(posedge clk_i) disable iff (!rst_ni) $onehot0(eu_ready_o));

  a_tag_unique: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    take |-> !(inflight[eu_tag_i[gidx]] && !tag_clr[eu_tag_i[gidx]]));

  a_rf_stable: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    rf_valid_o && !rf_ready_i |=> rf_valid_o &&
      $stable({stage_tag, stage_dst, stage_mask, stage_data}));

  for (genvar g = 0; g < NumEus; g++) begin : g_eu_chk
    a_eu_stable: assert property (
      @(posedge clk_i) disable iff (!rst_ni)
      eu_valid_i[g] && !eu_ready_o[g] |=> eu_valid_i[g] &&
        $stable({eu_tag_i[g], eu_dst_i[g], eu_act_mask_i[g], eu_data_i[g]}));
  end
`endif

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: directed scenarios then
// randomized traffic against a queue-based reference model.
module tb_result_collector;

  localparam int N  = 2;
  localparam int NT = 8;
  localparam int WW = 32;
  localparam int RI = 6;
  localparam int DW = 1024;
  localparam int TW = 3;

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           eu_valid_i;
  logic [N-1:0]           eu_ready_o;
  logic [N-1:0][TW-1:0]   eu_tag_i;
  logic [N-1:0][WW-1:0]   eu_act_mask_i;
  logic [N-1:0][RI-1:0]   eu_dst_i;
  logic [N-1:0][DW-1:0]   eu_data_i;
  logic                   rf_valid_o;
  logic                   rf_ready_i;
  logic [WW-1:0]          rf_act_mask_o;
  logic [RI-1:0]          rf_dst_o;
  logic [DW-1:0]          rf_data_o;
  logic                   disp_done_valid_o;
  logic [TW-1:0]          disp_done_tag_o;

  result_collector dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .eu_valid_i        (eu_valid_i),
    .eu_ready_o        (eu_ready_o),
    .eu_tag_i          (eu_tag_i),
    .eu_act_mask_i     (eu_act_mask_i),
    .eu_dst_i          (eu_dst_i),
    .eu_data_i         (eu_data_i),
    .rf_valid_o        (rf_valid_o),
    .rf_ready_i        (rf_ready_i),
    .rf_act_mask_o     (rf_act_mask_o),
    .rf_dst_o          (rf_dst_o),
    .rf_data_o         (rf_data_o),
    .disp_done_valid_o (disp_done_valid_o),
    .disp_done_tag_o   (disp_done_tag_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    logic [RI-1:0] dst;
    logic [WW-1:0] mask;
    logic [DW-1:0] data;
  } item_t;

  int    checks = 0;
  int    fails  = 0;
  item_t pay[N];
  bit    pend[N];
  bit    busy[NT];
  item_t q[$];
  int    mptr = 0;
  bit    mfull = 1'b0;
  bit    cur_full = 1'b0;
  bit    use_pool = 1'b0;
  int    nacc = 0;
  int    ncomp = 0;
  int    ndrop = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      eu_valid_i[i]    = pend[i];
      eu_tag_i[i]      = pay[i].tag;
      eu_dst_i[i]      = pay[i].dst;
      eu_act_mask_i[i] = pay[i].mask;
      eu_data_i[i]     = pay[i].data;
    end
  endtask

  task automatic offer(int i, logic [TW-1:0] tag, logic [RI-1:0] dst,
                       logic [WW-1:0] mask, logic [DW-1:0] data);
    pay[i].tag  = tag;
    pay[i].dst  = dst;
    pay[i].mask = mask;
    pay[i].data = data;
    pend[i]     = 1'b1;
    if (use_pool) busy[tag] = 1'b1;
    apply();
  endtask

  // Reference: stage accepts when empty or draining; the winner is
  // the first pending EU found scanning from the round-robin pointer.
  task automatic eval();
    int           w;
    int           j;
    bit           free;
    logic [N-1:0] er;
    cur_full = mfull;
    if (!rst_ni) begin
      chk("rst_rf_valid", rf_valid_o, 0);
      chk("rst_done_valid", disp_done_valid_o, 0);
      chk("rst_eu_ready", eu_ready_o, 0);
      chk("rst_dst", rf_dst_o, 0);
      chk("rst_mask", rf_act_mask_o, 0);
      chk("rst_tag", disp_done_tag_o, 0);
      chk("rst_data", rf_data_o[63:0], 0);
      mfull    = 1'b0;
      cur_full = 1'b0;
      mptr     = 0;
    end else begin
      free = !mfull || rf_ready_i;
      w    = -1;
      er   = '0;
      if (free) begin
        for (int k = 0; k < N; k++) begin
          j = (mptr + k) % N;
          if (pend[j] && w < 0) w = j;
        end
      end
      if (w >= 0) er[w] = 1'b1;
      chk("eu_ready", eu_ready_o, er);
      if (w >= 0) begin
        q.push_back(pay[w]);
        pend[w] = 1'b0;
        mptr    = (w + 1) % N;
        mfull   = 1'b1;
        nacc++;
      end else if (free) begin
        mfull = 1'b0;
      end
    end
  endtask

  task automatic tick();
    #1;
    eval();
    @(negedge clk);
    apply();
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  // Monitor: checks the RF side against the front of the expected queue.
  initial begin
    item_t e;
    forever begin
      @(negedge clk);
      #2;
      chk("rf_valid", rf_valid_o, cur_full);
      chk("done_valid", disp_done_valid_o, cur_full && rf_ready_i);
      if (cur_full) begin
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL scoreboard: stage valid with empty queue at %0t",
                   $time);
        end else begin
          e = q[0];
          chk("rf_dst", rf_dst_o, e.dst);
          chk("rf_mask", rf_act_mask_o, e.mask);
          for (int k = 0; k < DW / 64; k++)
            chk("rf_data", rf_data_o[k*64 +: 64], e.data[k*64 +: 64]);
          if (rf_ready_i) begin
            chk("done_tag", disp_done_tag_o, e.tag);
            busy[e.tag] = 1'b0;
            void'(q.pop_front());
            ncomp++;
          end
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] pat;
    logic [TW-1:0] ft[$];
    int            guard;
    pat = {128{8'hA5}};
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      pay[i]  = '{tag: '0, dst: '0, mask: '0, data: '0};
    end
    for (int t = 0; t < NT; t++) busy[t] = 1'b0;
    rst_ni     = 1'b0;
    rf_ready_i = 1'b1;
    apply();
    @(negedge clk);
    apply();
    repeat (3) tick();
    rst_ni = 1'b1;

    offer(0, 3'd3, 6'd5, 32'hFFFF_FFFF, pat);
    repeat (3) tick();

    for (int c = 0; c < 4; c++) begin
      if (!pend[0]) offer(0, 3'd1, 6'd10, 32'h0000_FFFF, rnd_data());
      if (!pend[1]) offer(1, 3'd2, 6'd11, 32'hFFFF_0000, rnd_data());
      tick();
    end
    repeat (4) tick();

    offer(0, 3'd4, 6'd20, 32'h1234_5678, rnd_data());
    tick();
    rf_ready_i = 1'b0;
    offer(1, 3'd2, 6'd21, 32'h8765_4321, rnd_data());
    repeat (3) tick();
    rf_ready_i = 1'b1;
    repeat (3) tick();

    for (int t = 5; t <= 7; t++) begin
      offer(1, 3'(t), 6'(t), 32'hA0A0_0000 | t, rnd_data());
      tick();
    end
    repeat (3) tick();

    offer(0, 3'd0, 6'd63, 32'h0, rnd_data());
    repeat (3) tick();

    rf_ready_i = 1'b0;
    offer(0, 3'd6, 6'd33, 32'hCAFE_F00D, rnd_data());
    repeat (2) tick();
    rst_ni = 1'b0;
    ndrop += q.size();
    q.delete();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    for (int t = 0; t < NT; t++) busy[t] = 1'b0;
    mfull    = 1'b0;
    cur_full = 1'b0;
    mptr     = 0;
    apply();
    repeat (2) tick();
    rst_ni     = 1'b1;
    rf_ready_i = 1'b1;
    offer(0, 3'd1, 6'd1, 32'h1, rnd_data());
    offer(1, 3'd2, 6'd2, 32'h2, rnd_data());
    repeat (4) tick();

    use_pool = 1'b1;
    for (int c = 0; c < 400; c++) begin
      rf_ready_i = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          ft.delete();
          for (int t = 0; t < NT; t++) if (!busy[t]) ft.push_back(3'(t));
          if (ft.size() > 0)
            offer(i, ft[$urandom_range(0, ft.size() - 1)], 6'($urandom),
                  ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom),
                  rnd_data());
        end
      end
      tick();
    end

    rf_ready_i = 1'b1;
    guard = 0;
    while ((q.size() != 0 || pend[0] || pend[1] || mfull) && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    chk("drain_queue_empty", q.size(), 0);
    chk("completion_count", ncomp, nacc - ndrop);
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
